// File: rtl/menu_param_ctrl.sv
// Front-panel menu controller: debounced buttons move a cursor over five BCD
// parameters and edit them; committed values only change on a frame boundary.

module menu_btn #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd8000000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd2000000,
    parameter bit          AUTO_REPEAT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    state_t      state;
    logic [1:0]  sync_q;
    logic [1:0]  vld_pipe;
    logic [19:0] db_cnt;
    logic [23:0] timer;
    logic        level, level_d, armed;
    logic        rise;

    // A button still held across reset stays disarmed until it is seen released.
    assign rise = level & ~level_d & armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            vld_pipe <= '0;
            db_cnt   <= '0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            vld_pipe <= {vld_pipe[0], 1'b1};
            level_d  <= level;
            if (sync_q[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                level  <= sync_q[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 20'd1;
            end
            if (vld_pipe[1] && !sync_q[1] && !level)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            case (state)
                IDLE: if (rise) begin
                    evt   <= 1'b1;
                    timer <= '0;
                    if (AUTO_REPEAT) state <= HELD;
                end
                HELD: if (!level) begin
                    state <= IDLE;
                end else if (timer == HOLD_CYCLES - 24'd1) begin
                    evt   <= 1'b1;
                    timer <= '0;
                    state <= REPEAT;
                end else begin
                    timer <= timer + 24'd1;
                end
                REPEAT: if (!level) begin
                    state <= IDLE;
                end else if (timer == REPEAT_CYCLES - 24'd1) begin
                    evt   <= 1'b1;
                    timer <= '0;
                end else begin
                    timer <= timer + 24'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module menu_param_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd8000000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd2000000,
    parameter logic [19:0] MODE_MAX        = 20'h00003,
    parameter logic [19:0] AGC_MAX         = 20'h00002,
    parameter logic [19:0] LVL1_MAX        = 20'h99999,
    parameter logic [19:0] LVL2_MAX        = 20'h09999,
    parameter logic [19:0] TINT_MAX        = 20'h00099
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        newframe,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_rst_val,
    output logic [19:0] out_mode,
    output logic [19:0] out_Type_AGC,
    output logic [19:0] out_Set_LVL1,
    output logic [19:0] out_Set_LVL2,
    output logic [19:0] out_Time_int,
    output logic [2:0]  cursor,
    output logic        changed
);
    localparam int N_ITEMS = 5;
    localparam int N_BTN   = 5;
    localparam int UP = 0, DN = 1, INC = 2, DEC = 3, RV = 4;
    localparam logic [N_ITEMS-1:0][19:0] ITEM_MAX =
        {TINT_MAX, LVL2_MAX, LVL1_MAX, AGC_MAX, MODE_MAX};

    logic [N_BTN-1:0]              raw, evt;
    logic [N_ITEMS-1:0][19:0]      shadow, out_q;
    logic [19:0]                   cur_val, cur_max, new_val;
    logic                          nav_up, nav_dn, edit_en, do_rst, do_inc, do_dec;

    assign raw = {btn_rst_val, btn_dec, btn_inc, btn_down, btn_up};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        menu_btn #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .AUTO_REPEAT     (i == INC || i == DEC)
        ) u_btn (
            .clk (clk),
            .rst (rst),
            .raw (raw[i]),
            .evt (evt[i])
        );
    end

    function automatic logic [19:0] bcd_inc(input logic [19:0] v);
        logic [19:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 5; d++) begin
            if (c) begin
                if (v[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
                else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [19:0] bcd_dec(input logic [19:0] v);
        logic [19:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < 5; d++) begin
            if (b) begin
                if (v[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'd9;
                else begin
                    r[4*d +: 4] = v[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Navigation (even a cancelled up+down) swallows any edit in the same cycle.
    assign nav_up  = evt[UP] & ~evt[DN];
    assign nav_dn  = evt[DN] & ~evt[UP];
    assign edit_en = ~(evt[UP] | evt[DN]);
    assign do_rst  = edit_en & evt[RV];
    assign do_inc  = edit_en & ~evt[RV] & evt[INC] & ~evt[DEC];
    assign do_dec  = edit_en & ~evt[RV] & evt[DEC] & ~evt[INC];

    always_comb begin
        cur_val = '0;
        cur_max = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (cursor == 3'(i)) begin
                cur_val = shadow[i];
                cur_max = ITEM_MAX[i];
            end
        end
        new_val = cur_val;
        if (do_rst)                           new_val = '0;
        else if (do_inc && cur_val < cur_max) new_val = bcd_inc(cur_val);
        else if (do_dec && cur_val != '0)     new_val = bcd_dec(cur_val);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow  <= '0;
            out_q   <= '0;
            cursor  <= '0;
            changed <= 1'b0;
        end else begin
            if (nav_up)      cursor <= (cursor == 3'd0) ? 3'd4 : cursor - 3'd1;
            else if (nav_dn) cursor <= (cursor == 3'd4) ? 3'd0 : cursor + 3'd1;
            for (int i = 0; i < N_ITEMS; i++)
                if (cursor == 3'(i)) shadow[i] <= new_val;
            // Commit samples the pre-edit shadow when an edit lands on the same edge.
            changed <= 1'b0;
            if (newframe) begin
                out_q   <= shadow;
                changed <= (shadow != out_q);
            end
        end
    end

    assign out_mode     = out_q[0];
    assign out_Type_AGC = out_q[1];
    assign out_Set_LVL1 = out_q[2];
    assign out_Set_LVL2 = out_q[3];
    assign out_Time_int = out_q[4];
endmodule

// File: tb/tb_menu_param_ctrl.sv
// Directed bench for menu_param_ctrl: navigation, BCD edits, auto-repeat,
// debounce, event priority, commit gating and reset while a button is held.

module tb_menu_param_ctrl;
    localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_INC = 5'b00100,
                           B_DEC = 5'b01000, B_RV = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        newframe = 1'b0;
    logic [4:0]  btn = '0;
    logic [19:0] out_mode, out_Type_AGC, out_Set_LVL1, out_Set_LVL2, out_Time_int;
    logic [2:0]  cursor;
    logic        changed;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    menu_param_ctrl #(
        .DEBOUNCE_CYCLES (20'd4),
        .HOLD_CYCLES     (24'd20),
        .REPEAT_CYCLES   (24'd5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .newframe     (newframe),
        .btn_up       (btn[0]),
        .btn_down     (btn[1]),
        .btn_inc      (btn[2]),
        .btn_dec      (btn[3]),
        .btn_rst_val  (btn[4]),
        .out_mode     (out_mode),
        .out_Type_AGC (out_Type_AGC),
        .out_Set_LVL1 (out_Set_LVL1),
        .out_Set_LVL2 (out_Set_LVL2),
        .out_Time_int (out_Time_int),
        .cursor       (cursor),
        .changed      (changed)
    );

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw level held for n sampling edges, then released and allowed to settle.
    task automatic hold(input logic [4:0] m, input int n);
        btn = m;
        idle(n);
        btn = '0;
        idle(12);
    endtask

    task automatic press(input logic [4:0] m);
        hold(m, 8);
    endtask

    task automatic commit();
        newframe = 1'b1;
        @(negedge clk);
        newframe = 1'b0;
    endtask

    initial begin
        idle(3);
        chk("rst_mode",    out_mode,     20'h0);
        chk("rst_lvl1",    out_Set_LVL1, 20'h0);
        chk("rst_tint",    out_Time_int, 20'h0);
        chk("rst_cursor",  20'(cursor),  20'h0);
        chk("rst_changed", 20'(changed), 20'h0);
        rst = 1'b1;
        idle(5);

        // Cursor walks down with wrap, then up wraps 0 -> 4.
        for (int k = 0; k < 6; k++) begin
            press(B_DN);
            commit();
            chk($sformatf("down_%0d", k), 20'(cursor), 20'((k + 1) % 5));
        end
        press(B_UP);
        chk("up_to_0", 20'(cursor), 20'h0);
        press(B_UP);
        chk("up_wrap", 20'(cursor), 20'h4);

        // Auto-repeat on Time_int: press + entry + 3 repeats, released before a 4th.
        hold(B_INC, 38);
        commit();
        chk("rep_tint",    out_Time_int, 20'h00005);
        chk("rep_changed", 20'(changed), 20'h1);
        hold(B_INC, 600);
        commit();
        chk("rep_sat_tint", out_Time_int, 20'h00099);

        // Set_LVL2 driven through every carry up to its maximum, then saturation.
        press(B_UP);
        chk("sel_lvl2", 20'(cursor), 20'h3);
        hold(B_INC, 50100);
        commit();
        chk("lvl2_max", out_Set_LVL2, 20'h09999);
        press(B_INC);
        commit();
        chk("lvl2_sat",     out_Set_LVL2, 20'h09999);
        chk("lvl2_sat_chg", 20'(changed), 20'h0);

        // Set_LVL1: exactly 1000 steps gives 01000, then a borrow chain.
        press(B_UP);
        hold(B_INC, 5013);
        commit();
        chk("lvl1_carry", out_Set_LVL1, 20'h01000);
        press(B_DEC);
        commit();
        chk("lvl1_borrow", out_Set_LVL1, 20'h00999);
        chk("lvl2_untouched", out_Set_LVL2, 20'h09999);

        // Mode: decrement saturates at 0, increment at 3.
        press(B_UP);
        press(B_UP);
        chk("sel_mode", 20'(cursor), 20'h0);
        press(B_DEC);
        commit();
        chk("mode_zero_sat", out_mode, 20'h0);
        hold(B_INC, 38);
        commit();
        chk("mode_max_sat", out_mode, 20'h00003);

        // Short glitch rejected; a real press still acts.
        hold(B_DEC, 3);
        commit();
        chk("glitch", out_mode, 20'h00003);
        press(B_DEC);
        commit();
        chk("dec_after_glitch", out_mode, 20'h00002);

        // Simultaneous events.
        press(B_UP | B_DN);
        chk("up_dn_cancel", 20'(cursor), 20'h0);
        press(B_INC | B_RV);
        commit();
        chk("rv_beats_inc", out_mode, 20'h0);
        press(B_DN | B_INC);
        commit();
        chk("nav_with_inc_cur",  20'(cursor), 20'h1);
        chk("nav_with_inc_mode", out_mode,    20'h0);
        press(B_UP);

        // Edit landing on the newframe edge is committed one frame later.
        btn = B_INC;
        idle(7);
        newframe = 1'b1;
        @(negedge clk);
        newframe = 1'b0;
        chk("coincide_old", out_mode, 20'h0);
        btn = '0;
        idle(12);
        commit();
        chk("coincide_new", out_mode, 20'h00001);

        // Reset while inc is held; the held button must not act afterwards.
        btn = B_INC;
        idle(30);
        rst = 1'b0;
        #1;
        chk("arst_mode",   out_mode,     20'h0);
        chk("arst_lvl2",   out_Set_LVL2, 20'h0);
        chk("arst_tint",   out_Time_int, 20'h0);
        idle(3);
        rst = 1'b1;
        idle(40);
        btn = '0;
        idle(12);
        commit();
        chk("held_thru_rst",     out_mode,     20'h0);
        chk("held_thru_rst_chg", 20'(changed), 20'h0);
        press(B_INC);
        commit();
        chk("repress_after_rst", out_mode, 20'h00001);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/menu_param_ctrl.md
# menu_param_ctrl

Button-driven parameter controller for the on-screen menu. Debounces five front-panel buttons, moves a cursor over the five menu items, and edits the selected item's value in packed BCD. It feeds the text renderer's `input_mode`, `input_Type_AGC`, `input_Set_LVL1`, `input_Set_LVL2` and `input_Time_int` inputs. Outputs update only on `newframe`, so a value never changes mid-frame.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 20'd500000: the synchronised input must be stable this many clk cycles before a level is accepted.
- `HOLD_CYCLES`, default 24'd8000000: how long inc/dec must be held before auto-repeat starts.
- `REPEAT_CYCLES`, default 24'd2000000: auto-repeat period.
- `MODE_MAX`, default 20'h00003: upper bound of mode, in BCD.
- `AGC_MAX`, default 20'h00002.
- `LVL1_MAX`, default 20'h99999.
- `LVL2_MAX`, default 20'h09999.
- `TINT_MAX`, default 20'h00099.

**Ports** (name, direction, width, meaning)
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `newframe` in 1: one-cycle pulse per frame; commits the shadow values to the outputs.
- `btn_up` in 1: raw, asynchronous button, active-high; cursor up.
- `btn_down` in 1: raw, asynchronous button, active-high; cursor down.
- `btn_inc` in 1: raw, asynchronous button, active-high; increment the selected value.
- `btn_dec` in 1: raw, asynchronous button, active-high; decrement the selected value.
- `btn_rst_val` in 1: raw, asynchronous button, active-high; clear the selected value to 0.
- `out_mode` out 20: packed BCD, 5 digits, [19:16] is the MS digit.
- `out_Type_AGC` out 20: packed BCD, same format.
- `out_Set_LVL1` out 20: packed BCD, same format.
- `out_Set_LVL2` out 20: packed BCD, same format.
- `out_Time_int` out 20: packed BCD, same format.
- `cursor` out 3: selected item. 0 = mode, 1 = Type_AGC, 2 = Set_LVL1, 3 = Set_LVL2, 4 = Time_int.
- `changed` out 1: one-cycle pulse on the `newframe` cycle when any committed value differs from the previous outputs.

## Operation

**Input conditioning**
- Each button passes through a 2-FF synchroniser, then its own debounce counter. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive cycles at the new level.
- A press event is a 0→1 edge of the debounced level, one cycle wide.

**Cursor**
- up: `cursor` is decremented, wrapping 0→4.
- down: `cursor` is incremented, wrapping 4→0.

**Value edit on the selected shadow register**
- inc: BCD +1 with carry through all 5 digits. Saturates at the item's `*_MAX`; no wrap.
- dec: BCD −1 with borrow. Saturates at 0.
- rst_val: the selected shadow register is set to 20'h00000.

**Auto-repeat** (inc and dec only), per-button FSM:
- States: IDLE → HELD → REPEAT.
- IDLE → HELD on a press event. The press event itself performs one step.
- HELD → REPEAT after `HOLD_CYCLES` of continuous debounced-high. Entering REPEAT performs one step.
- In REPEAT, one step every `REPEAT_CYCLES`.
- Any state → IDLE when the debounced level drops.

**Simultaneous events in one cycle** (priority top to bottom):
1. up and down together: both ignored.
2. Any navigation event: navigation applied; inc/dec/rst_val in the same cycle are ignored.
3. inc and dec together: both ignored.
4. rst_val with inc or dec: rst_val wins.

**Commit**
- On `newframe`, all shadow registers are copied to the outputs in the same cycle.
- If an edit and `newframe` coincide, the pre-edit shadow value is committed; the edit appears at the next `newframe`.

**Invariants**
- Only the selected item ever changes.
- Every value has valid BCD digits (0–9) and stays ≤ its `*_MAX`.

## Timing

**Reset** (`rst`=0, asynchronous)
- All shadow registers and outputs 20'h00000.
- `cursor` 0, `changed` 0.
- Debounce counters, synchronisers and FSMs cleared to IDLE / 0.
- Reset mid-hold: the button must be released and pressed again before it acts.

**Latency**
- Raw edge → debounced level: 2 + `DEBOUNCE_CYCLES` cycles.
- Debounced level → press event: 1 cycle.
- Press event → shadow or `cursor` updated: 1 cycle. `cursor` is registered and updates directly, not gated by `newframe`.
- Shadow → output: committed on the first `newframe` after the update; outputs are registered, visible the cycle after the pulse.
- `changed` is asserted in the same cycle the outputs update.

**Boundary behaviour**
- Debounce: a glitch shorter than `DEBOUNCE_CYCLES` produces no event.
- Carry: 20'h09999 + 1 = 20'h10000 when the max allows.
- Borrow: 20'h10000 − 1 = 20'h09999.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=5.

1. **Reset and wrap.** Release reset, then press down 6 times, committing with `newframe` after each. Require: all outputs 0 and `changed`=0 after reset; `cursor` sequence 1,2,3,4,0,1. Press up from 0 → `cursor`=4.
2. **BCD carry and saturation.** Select item 3 and preload to 20'h09998 via inc presses. Press inc twice, then `newframe`. Require `out_Set_LVL2`=20'h09999. A further inc leaves 20'h09999; `changed`=0 at that commit.
3. **Borrow and zero saturation.** Select item 2 with value 20'h10000, press dec, `newframe` → 20'h09999. Select item 0 with value 0: dec keeps 20'h00000.
4. **Auto-repeat.** Hold inc on item 4 for 2+4+1+20+3×5 cycles. Require exactly 5 increments (press + entry + 3 repeats) → `out_Time_int`=20'h00005 after `newframe`. After that, with the value at 20'h00099, further holding stays at 20'h00099.
5. **Debounce and simultaneous events.** A 3-cycle glitch on `btn_inc` → no change. up+down in the same cycle → `cursor` unchanged. inc+rst_val together → value 0.
6. **Commit gating and async reset.** An edit coinciding with `newframe` is committed at the next `newframe`. Assert `rst` mid-hold of inc → everything returns to 0. Keep inc held through release of reset → no step until the button is released and pressed again.
